vecadd_out_fifo: RTL and testbench
==================================

# vecadd_out_fifo

First-word-fall-through stream FIFO that carries 32-bit tokens plus an end-of-transaction (EOT) flag. It sits directly downstream of `VecAdd`: it accepts the `c_s` output stream (`din/din_eot/write/full_n`) and presents a TAPA-style read port (`dout/dout_eot/empty_n/read/peek`) to the next consumer stage. It also counts completed transactions for host-visible status.

## Interface
Parameters:
- `WIDTH`, 32, data width in bits, excluding the EOT bit.
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `CNT_W`, 16, width of the transaction counter.

Ports:
- `ap_clk` in 1: sole clock; all state updates on its rising edge.
- `ap_rst` in 1: reset, synchronous, active-high.
- `s_din` in WIDTH: write data.
- `s_din_eot` in 1: EOT flag accompanying `s_din`.
- `s_write` in 1: write strobe; accepted only when `s_full_n`=1.
- `s_full_n` out 1: space available (registered).
- `m_dout` out WIDTH: head-of-queue data; valid when `m_empty_n`=1.
- `m_dout_eot` out 1: EOT flag of head entry.
- `m_peek` out WIDTH: identical to `m_dout`; read without consuming.
- `m_empty_n` out 1: head entry valid (registered).
- `m_read` in 1: consume strobe; accepted only when `m_empty_n`=1.
- `count` out $clog2(DEPTH)+1: occupancy, 0..DEPTH.
- `txn_done` out 1: one-cycle pulse when an EOT entry is consumed.
- `txn_count` out CNT_W: number of EOT entries consumed since reset; saturates at all-ones.

## Operation
- Storage: DEPTH×(WIDTH+1) register array, write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits, wrap modulo DEPTH naturally; occupancy register `count`.
- Accepted write `wr = s_write & s_full_n`: array[wp] ← {s_din_eot, s_din}; wp+1.
- Accepted read `rd = m_read & m_empty_n`: rp+1.
- `m_dout`/`m_dout_eot`/`m_peek` = array[rp] (combinational from registered array); value undefined-but-stable when empty; bench must not check it then.
- `count` next: +1 on wr only, −1 on rd only, unchanged on both or neither.
- `s_full_n` next = (count_next ≠ DEPTH); `m_empty_n` next = (count_next ≠ 0).
- Strobes on a deasserted flag (write while full, read while empty) ignored: no pointer, count or array change.
- EOT is an ordinary token for storage: it occupies one entry, ordering preserved; the EOT token's data word passes through unchanged.
- `txn_done` registered: next = rd & m_dout_eot. `txn_count` increments on the same condition unless already all-ones.
- No bypass: a word written into an empty FIFO is not visible in the write cycle.

## Timing
- Reset (ap_rst=1 at an edge): wp=rp=0, count=0, s_full_n=1, m_empty_n=0, txn_done=0, txn_count=0. Array contents not reset. Reset mid-operation discards all stored tokens including pending EOT; no txn_done for discarded entries.
- Write latency: write accepted at edge N → m_empty_n=1 and m_dout valid after edge N (usable at edge N+1).
- Read: data is presented before read; consumer samples m_dout in the same cycle it asserts m_read.
- Full: after DEPTH accepted writes with no reads, s_full_n=0 after that edge; one read reopens it after the next edge.
- Simultaneous wr & rd at count=DEPTH: impossible (s_full_n=0). At count=0: impossible (m_empty_n=0). At 0<count<DEPTH: both accepted, count unchanged, flags unchanged.
- Sustained throughput: one token per cycle when 0<count<DEPTH with both sides active.
- txn_done: asserted the cycle after the edge consuming the EOT entry, for exactly one cycle.

## Test plan
- Reset check: hold ap_rst 3 cycles → s_full_n=1, m_empty_n=0, count=0, txn_count=0, txn_done=0.
- Stream VecAdd results 0x3F800000, 0x40400000, 0x40A00000, 0x40E00000, 0x41100000 (1.0,3.0,5.0,7.0,9.0) then EOT word 0, consumer always reading → outputs in same order, m_dout_eot=1 only on 6th token, txn_done one pulse, txn_count=1.
- Fill: DEPTH=4, 5 writes with m_read=0 → first 4 accepted, s_full_n=0 after 4th, 5th ignored, count=4; then drain 4 → values 1st–4th, m_empty_n=0 after last.
- Simultaneous: count=2, assert s_write and m_read together for 10 cycles with data 0..9 → count stays 2, s_full_n and m_empty_n stay 1, data emerges in order.
- Illegal strobes: m_read=1 while empty and s_write=1 while full → no change to count, pointers or outputs.
- Mid-run reset: count=3 with pending EOT, pulse ap_rst one cycle → count=0, m_empty_n=0, txn_count=0, no txn_done; next 2-token stream with EOT passes correctly, txn_count=1.

Source files
------------

// File: rtl/vecadd_out_fifo.sv
// vecadd_out_fifo: first-word-fall-through FIFO carrying WIDTH-bit tokens plus
// an end-of-transaction flag, placed downstream of VecAdd. The write side takes
// the c_s stream; the read side is a TAPA-style port with a peek view. The block
// also counts consumed EOT tokens as completed transactions for host status.
module vecadd_out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic [WIDTH-1:0]         s_din,
    input  logic                     s_din_eot,
    input  logic                     s_write,
    output logic                     s_full_n,
    output logic [WIDTH-1:0]         m_dout,
    output logic                     m_dout_eot,
    output logic [WIDTH-1:0]         m_peek,
    output logic                     m_empty_n,
    input  logic                     m_read,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     txn_done,
    output logic [CNT_W-1:0]         txn_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Storage: each entry holds {eot, data}
    logic [WIDTH:0]    mem_q [DEPTH];

    logic [AW-1:0]     wp_q, wp_d;
    logic [AW-1:0]     rp_q, rp_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_n_q, full_n_d;
    logic              empty_n_q, empty_n_d;
    logic              txn_done_q, txn_done_d;
    logic [CNT_W-1:0]  txn_count_q, txn_count_d;

    logic              wr;
    logic              rd;
    logic [WIDTH:0]    head;

    // Transaction counter saturates at all-ones rather than wrapping, so the
    // host never sees a small count after a very long run.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Handshake qualification, pointer/occupancy/flag next-state and transaction tracking
    always_comb begin
        wr          = s_write & full_n_q;
        rd          = m_read & empty_n_q;
        head        = mem_q[rp_q];
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        txn_done_d  = 1'b0;
        txn_count_d = txn_count_q;

        if (wr) begin
            wp_d = wp_q + PTR_ONE;
        end
        if (rd) begin
            rp_d = rp_q + PTR_ONE;
        end

        // Simultaneous accept leaves occupancy unchanged
        case ({wr, rd})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Flags are registered from the next occupancy so they are glitch-free
        full_n_d  = (count_d != FULL_LVL);
        empty_n_d = (count_d != '0);

        // A transaction completes when its EOT token leaves the FIFO
        if (rd && head[WIDTH]) begin
            txn_done_d  = 1'b1;
            txn_count_d = sat_inc(txn_count_q);
        end
    end

    // Control state register; reset discards every stored token including a pending EOT
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            full_n_q    <= 1'b1;
            empty_n_q   <= 1'b0;
            txn_done_q  <= 1'b0;
            txn_count_q <= '0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            full_n_q    <= full_n_d;
            empty_n_q   <= empty_n_d;
            txn_done_q  <= txn_done_d;
            txn_count_q <= txn_count_d;
        end
    end

    // Data array is not reset; a write is only committed when it is accepted
    always_ff @(posedge ap_clk) begin
        if (wr && !ap_rst) begin
            mem_q[wp_q] <= {s_din_eot, s_din};
        end
    end

    // Head of queue is presented combinationally from the registered array (no write bypass)
    always_comb begin
        m_dout     = head[WIDTH-1:0];
        m_peek     = head[WIDTH-1:0];
        m_dout_eot = head[WIDTH];
        s_full_n   = full_n_q;
        m_empty_n  = empty_n_q;
        count      = count_q;
        txn_done   = txn_done_q;
        txn_count  = txn_count_q;
    end

endmodule

// File: tb/tb_vecadd_out_fifo.sv
// Directed testbench for vecadd_out_fifo (WIDTH=32, DEPTH=4, CNT_W=16).
module tb_vecadd_out_fifo;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [31:0] s_din;
    logic        s_din_eot;
    logic        s_write;
    logic        s_full_n;
    logic [31:0] m_dout;
    logic        m_dout_eot;
    logic [31:0] m_peek;
    logic        m_empty_n;
    logic        m_read;
    logic [2:0]  count;
    logic        txn_done;
    logic [15:0] txn_count;

    int checks   = 0;
    int failures = 0;

    vecadd_out_fifo #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .s_din      (s_din),
        .s_din_eot  (s_din_eot),
        .s_write    (s_write),
        .s_full_n   (s_full_n),
        .m_dout     (m_dout),
        .m_dout_eot (m_dout_eot),
        .m_peek     (m_peek),
        .m_empty_n  (m_empty_n),
        .m_read     (m_read),
        .count      (count),
        .txn_done   (txn_done),
        .txn_count  (txn_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic wr_one(input logic [31:0] d, input logic e);
        s_write   = 1'b1;
        s_din     = d;
        s_din_eot = e;
        step();
        s_write   = 1'b0;
        s_din_eot = 1'b0;
    endtask

    logic [31:0] vec [6];
    logic [31:0] simq [12];
    int          wi;
    int          ri;
    int          pulses;

    initial begin
        ap_rst    = 1'b1;
        s_din     = '0;
        s_din_eot = 1'b0;
        s_write   = 1'b0;
        m_read    = 1'b0;

        // Reset held three cycles
        repeat (3) step();
        chk("rst_full_n",    s_full_n,  1);
        chk("rst_empty_n",   m_empty_n, 0);
        chk("rst_count",     count,     0);
        chk("rst_txn_count", txn_count, 0);
        chk("rst_txn_done",  txn_done,  0);
        ap_rst = 1'b0;

        // VecAdd stream 1.0,3.0,5.0,7.0,9.0 then EOT word 0, consumer always reading
        vec[0] = 32'h3F80_0000; vec[1] = 32'h4040_0000; vec[2] = 32'h40A0_0000;
        vec[3] = 32'h40E0_0000; vec[4] = 32'h4110_0000; vec[5] = 32'h0000_0000;
        wi = 0; ri = 0; pulses = 0;
        m_read = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (txn_done) pulses++;
            if (m_empty_n) begin
                if (ri < 6) begin
                    chk($sformatf("stream_dout%0d", ri), m_dout, vec[ri]);
                    chk($sformatf("stream_eot%0d", ri), m_dout_eot, (ri == 5) ? 1 : 0);
                    chk($sformatf("stream_peek%0d", ri), m_peek, vec[ri]);
                end
                ri++;
            end
            if (wi < 6 && s_full_n) begin
                s_write   = 1'b1;
                s_din     = vec[wi];
                s_din_eot = (wi == 5);
                wi++;
            end else begin
                s_write   = 1'b0;
                s_din_eot = 1'b0;
            end
            step();
        end
        m_read = 1'b0;
        chk("stream_tokens",    ri,        6);
        chk("stream_pulses",    pulses,    1);
        chk("stream_txn_count", txn_count, 1);
        chk("stream_empty",     m_empty_n, 0);

        // Fill: five writes with no reads; the fifth is dropped
        for (int i = 0; i < 5; i++) begin
            wr_one(32'hA0 + i, 1'b0);
            if (i < 4) chk($sformatf("fill_count%0d", i), count, i + 1);
        end
        chk("fill_full_n",  s_full_n,  0);
        chk("fill_count",   count,     4);
        chk("fill_empty_n", m_empty_n, 1);
        m_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_dout%0d", i), m_dout, 32'hA0 + i);
            step();
            if (i == 0) chk("drain_reopen", s_full_n, 1);
        end
        m_read = 1'b0;
        chk("drain_empty_n", m_empty_n, 0);
        chk("drain_count",   count,     0);

        // Simultaneous read and write at count=2
        wr_one(32'h100, 1'b0);
        wr_one(32'h101, 1'b0);
        simq[0] = 32'h100; simq[1] = 32'h101;
        for (int i = 0; i < 10; i++) simq[i + 2] = i;
        s_write = 1'b1;
        m_read  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_din = i;
            chk($sformatf("sim_dout%0d", i), m_dout, simq[i]);
            step();
            chk($sformatf("sim_count%0d", i), count, 2);
            chk($sformatf("sim_flags%0d", i), {s_full_n, m_empty_n}, 2'b11);
        end
        s_write = 1'b0;
        for (int i = 10; i < 12; i++) begin
            chk($sformatf("sim_tail%0d", i), m_dout, simq[i]);
            step();
        end
        m_read = 1'b0;
        chk("sim_empty", m_empty_n, 0);

        // Read strobe while empty is ignored
        m_read = 1'b1;
        step();
        step();
        m_read = 1'b0;
        chk("ill_rd_count",   count,     0);
        chk("ill_rd_empty_n", m_empty_n, 0);
        chk("ill_rd_full_n",  s_full_n,  1);
        for (int i = 0; i < 4; i++) wr_one(32'h55 + i, 1'b0);
        chk("ill_head", m_dout, 32'h55);
        // Write strobe while full is ignored (would otherwise overwrite the head slot)
        wr_one(32'hDEAD, 1'b1);
        chk("ill_wr_count", count,  4);
        chk("ill_wr_head",  m_dout, 32'h55);
        chk("ill_wr_eot",   m_dout_eot, 0);
        m_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ill_drain%0d", i), m_dout, 32'h55 + i);
            step();
        end
        m_read = 1'b0;
        chk("ill_txn_count", txn_count, 1);

        // Mid-run reset with a pending EOT
        wr_one(32'h1, 1'b0);
        wr_one(32'h2, 1'b0);
        wr_one(32'h0, 1'b1);
        chk("mr_count_pre", count, 3);
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        chk("mr_count",     count,     0);
        chk("mr_empty_n",   m_empty_n, 0);
        chk("mr_txn_count", txn_count, 0);
        chk("mr_txn_done",  txn_done,  0);
        step();
        chk("mr_txn_done2", txn_done,  0);
        wr_one(32'h11, 1'b0);
        wr_one(32'h22, 1'b1);
        pulses = 0;
        m_read = 1'b1;
        chk("mr_dout0", m_dout, 32'h11);
        chk("mr_eot0",  m_dout_eot, 0);
        step();
        if (txn_done) pulses++;
        chk("mr_dout1", m_dout, 32'h22);
        chk("mr_eot1",  m_dout_eot, 1);
        step();
        m_read = 1'b0;
        if (txn_done) pulses++;
        step();
        if (txn_done) pulses++;
        chk("mr_pulses",     pulses,    1);
        chk("mr_txn_count2", txn_count, 1);
        chk("mr_empty_end",  m_empty_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
